commit_unit: RTL and testbench

// - Receive end of the ROB commit bus (writeCommit outputBus).
// - Per committed instruction, applies the architectural side effects:
//   - register-file write
//   - store release to data memory
//   - branch predictor and BTB update
//   - misprediction recovery
// - Sits between the reorder buffer and the regfile, data memory, gshare/BTB and fetch.
// - Produces cpu_reset and priorCommit, which feed back into the ROB.

---
 rtl/commit_pkg.sv | 47 ++++
 rtl/commit_store_queue.sv | 77 +++++++
 rtl/commit_unit.sv | 174 +++++++++++++++++
 tb/tb_commit_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// Shared types and field positions for the commit stage: the writeCommit bus layout,
// store-queue entry format and recovery FSM states.
package commit_pkg;

    localparam int WIDTH    = 31;
    localparam int CONTROL  = 5;
    localparam int INDEX    = 7;
    localparam int ROB      = 2;
    localparam int SQ_DEPTH = 4;

    localparam int CI_BRANCH   = 0;
    localparam int CI_JUMP     = 1;
    localparam int CI_MEMWRITE = 2;
    localparam int CI_REGWRITE = 3;

    localparam int CF_RESET     = 0;
    localparam int CF_TAKEN     = 1;
    localparam int CF_WRITEBTB  = 2;
    localparam int CF_NEXT_LO   = 3;
    localparam int CF_NEXT_HI   = 4;
    localparam int CF_ISCONTROL = 5;

    localparam logic [WIDTH:0] ZERO_WORD = {(WIDTH+1){1'b0}};

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } commit_state_t;

    typedef struct packed {
        logic [WIDTH:0] addr;
        logic [WIDTH:0] data;
    } sq_entry_t;

    typedef struct packed {
        logic             validCommit;
        logic [WIDTH:0]   result;
        logic [WIDTH:0]   destCommit;
        logic [3:0]       commitInfo;
        logic [CONTROL:0] controlFlow;
        logic [WIDTH:0]   targetAddress;
        logic [WIDTH:0]   oldPC;
        logic [INDEX:0]   previousIndex;
        logic [WIDTH:0]   statusSnap;
    } commit_bus_t;

endpackage

// File: rtl/commit_store_queue.sv
// Committed-store FIFO: stores leave the ROB here and drain to data memory at the
// memory's pace. Also holds the overflow checker used by the commit unit.
module commit_store_queue
    import commit_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH,
    localparam int PW = $clog2(DEPTH)
)(
    input  logic      clk,
    input  logic      reset,
    input  logic      enq,
    input  sq_entry_t enqData,
    input  logic      deq,
    output sq_entry_t head,
    output logic [PW:0] count,
    output logic      full,
    output logic      empty
);

    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    sq_entry_t       entries_r [DEPTH];
    logic [PW-1:0]   wrPtr_r;
    logic [PW-1:0]   rdPtr_r;
    logic [PW:0]     count_r;
    logic            doEnq_s;
    logic            doDeq_s;

    // Status flags, qualified handshakes and head presentation
    always_comb begin
        full    = (count_r == DEPTH_C);
        empty   = (count_r == {(PW+1){1'b0}});
        doEnq_s = enq & ~full;
        doDeq_s = deq & ~empty;
        count   = count_r;
        if (empty) begin
            head = '{addr: ZERO_WORD, data: ZERO_WORD};
        end else begin
            head = entries_r[rdPtr_r];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
        end else begin
            if (doEnq_s) wrPtr_r <= wrPtr_r + PW'(1'b1);
            if (doDeq_s) rdPtr_r <= rdPtr_r + PW'(1'b1);
            case ({doEnq_s, doDeq_s})
                2'b10:   count_r <= count_r + (PW+1)'(1'b1);
                2'b01:   count_r <= count_r - (PW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (doEnq_s) entries_r[wrPtr_r] <= enqData;
    end

endmodule

module commit_sq_checker (
    input logic clk,
    input logic reset,
    input logic enq,
    input logic full
);

    // A store arriving at a full queue means the stall slack was not honoured
    sqOverflow: assert property (@(posedge clk) disable iff (!reset) !(enq && full));

endmodule

// File: rtl/commit_unit.sv
// Receive end of the ROB commit bus: applies register writes, store release,
// predictor/BTB update and misprediction recovery, all through output registers.
module commit_unit
    import commit_pkg::*;
#(
    parameter int QUEUE_DEPTH = SQ_DEPTH
)(
    input  logic              clk,
    input  logic              reset,
    input  commit_bus_t       commit,
    input  logic [ROB:0]      commit_rob,
    output logic              rf_we,
    output logic [4:0]        rf_addr,
    output logic [WIDTH:0]    rf_data,
    output logic [ROB:0]      rf_tag,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [WIDTH:0]    mem_addr,
    output logic [WIDTH:0]    mem_data,
    output logic              commit_stall,
    output logic              pred_update,
    output logic [INDEX:0]    pht_index,
    output logic [1:0]        pht_state,
    output logic              pht_taken,
    output logic              btb_we,
    output logic [WIDTH:0]    btb_pc,
    output logic [WIDTH:0]    btb_target,
    output logic              cpu_reset,
    output logic              prior_commit,
    output logic              redirect_valid,
    output logic [WIDTH:0]    redirect_pc,
    output logic              status_restore,
    output logic [WIDTH:0]    status_snap,
    output logic [31:0]       retire_count
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LEVEL = CW'(QUEUE_DEPTH - 1);

    commit_state_t   state_r;
    commit_state_t   stateNext_s;
    logic            accept_s;
    logic            regWrite_s;
    logic            storeReq_s;
    logic            ctrlUpdate_s;
    logic            mispredict_s;
    logic            sqEnq_s;
    logic            sqDeq_s;
    logic            sqFull_s;
    logic            sqEmpty_s;
    logic [CW-1:0]   sqCount_s;
    logic [CW-1:0]   sqLevel_s;
    sq_entry_t       sqHead_s;
    sq_entry_t       sqEnqData_s;
    logic            unusedInfo_s;

    assign unusedInfo_s = ^{commit.commitInfo[CI_JUMP], commit.commitInfo[CI_BRANCH]};

    // Commit acceptance and field decode; nothing is accepted during the flush cycle
    always_comb begin
        if (state_r == RUN) begin
            accept_s = commit.validCommit;
        end else begin
            accept_s = 1'b0;
        end
        regWrite_s   = accept_s & commit.commitInfo[CI_REGWRITE]
                     & (commit.destCommit[4:0] != 5'd0);
        storeReq_s   = accept_s & commit.commitInfo[CI_MEMWRITE];
        ctrlUpdate_s = accept_s & commit.controlFlow[CF_ISCONTROL];
        mispredict_s = accept_s & commit.controlFlow[CF_RESET];
        sqEnqData_s  = '{addr: commit.destCommit, data: commit.result};
    end

    // Store-queue handshakes and the occupancy the queue will hold after this edge
    always_comb begin
        sqEnq_s   = storeReq_s & ~sqFull_s;
        sqDeq_s   = ~sqEmpty_s & mem_ready;
        sqLevel_s = sqCount_s + CW'(sqEnq_s) - CW'(sqDeq_s);
    end

    // Recovery FSM next state: FLUSH always lasts exactly one cycle
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            RUN: begin
                if (mispredict_s) begin
                    stateNext_s = FLUSH;
                end else begin
                    stateNext_s = RUN;
                end
            end
            FLUSH:   stateNext_s = RUN;
            default: stateNext_s = RUN;
        endcase
    end

    // Recovery FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Side-effect output registers; payload fields are zeroed when their strobe is idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we          <= 1'b0;
            rf_addr        <= 5'd0;
            rf_data        <= ZERO_WORD;
            rf_tag         <= {(ROB+1){1'b0}};
            pred_update    <= 1'b0;
            pht_index      <= {(INDEX+1){1'b0}};
            pht_state      <= 2'd0;
            pht_taken      <= 1'b0;
            btb_we         <= 1'b0;
            btb_pc         <= ZERO_WORD;
            btb_target     <= ZERO_WORD;
            cpu_reset      <= 1'b0;
            prior_commit   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= ZERO_WORD;
            status_restore <= 1'b0;
            status_snap    <= ZERO_WORD;
            retire_count   <= 32'd0;
            commit_stall   <= 1'b0;
        end else begin
            rf_we          <= regWrite_s;
            rf_addr        <= regWrite_s ? commit.destCommit[4:0] : 5'd0;
            rf_data        <= regWrite_s ? commit.result : ZERO_WORD;
            rf_tag         <= regWrite_s ? commit_rob : {(ROB+1){1'b0}};
            pred_update    <= ctrlUpdate_s;
            pht_index      <= ctrlUpdate_s ? commit.previousIndex : {(INDEX+1){1'b0}};
            pht_state      <= ctrlUpdate_s ? commit.controlFlow[CF_NEXT_HI:CF_NEXT_LO] : 2'd0;
            pht_taken      <= ctrlUpdate_s & commit.controlFlow[CF_TAKEN];
            btb_we         <= ctrlUpdate_s & commit.controlFlow[CF_WRITEBTB];
            btb_pc         <= ctrlUpdate_s ? commit.oldPC : ZERO_WORD;
            btb_target     <= ctrlUpdate_s ? commit.targetAddress : ZERO_WORD;
            cpu_reset      <= mispredict_s;
            prior_commit   <= accept_s;
            redirect_valid <= mispredict_s;
            redirect_pc    <= mispredict_s ? commit.targetAddress : ZERO_WORD;
            status_restore <= mispredict_s;
            status_snap    <= mispredict_s ? commit.statusSnap : ZERO_WORD;
            retire_count   <= retire_count + {31'd0, accept_s};
            commit_stall   <= (sqLevel_s >= STALL_LEVEL);
        end
    end

    commit_store_queue #(.DEPTH(QUEUE_DEPTH)) u_sq (
        .clk     (clk),
        .reset   (reset),
        .enq     (sqEnq_s),
        .enqData (sqEnqData_s),
        .deq     (sqDeq_s),
        .head    (sqHead_s),
        .count   (sqCount_s),
        .full    (sqFull_s),
        .empty   (sqEmpty_s)
    );

    commit_sq_checker u_sqChk (
        .clk   (clk),
        .reset (reset),
        .enq   (storeReq_s),
        .full  (sqFull_s)
    );

    assign mem_valid = ~sqEmpty_s;
    assign mem_addr  = sqHead_s.addr;
    assign mem_data  = sqHead_s.data;

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: per-cycle expected side effects are queued when a
// commit is driven and compared one cycle later; a store-queue model tracks mem_*.
module tb_commit_unit;
    import commit_pkg::*;

    typedef struct {
        logic        rfWe;
        logic [4:0]  rfAddr;
        logic [31:0] rfData;
        logic [2:0]  rfTag;
        logic        pred;
        logic [7:0]  phtIndex;
        logic [1:0]  phtState;
        logic        phtTaken;
        logic        btbWe;
        logic [31:0] btbPc;
        logic [31:0] btbTarget;
        logic        flush;
        logic [31:0] redirectPc;
        logic [31:0] snap;
        logic        prior;
        logic [31:0] retire;
    } exp_t;

    logic clk, reset;
    commit_bus_t commit;
    logic [2:0] commit_rob;
    logic rf_we, mem_valid, mem_ready, commit_stall, pred_update, pht_taken, btb_we;
    logic cpu_reset, prior_commit, redirect_valid, status_restore;
    logic [4:0] rf_addr;
    logic [2:0] rf_tag;
    logic [7:0] pht_index;
    logic [1:0] pht_state;
    logic [31:0] rf_data, mem_addr, mem_data, btb_pc, btb_target, redirect_pc, status_snap, retire_count;

    exp_t      expQ[$];
    sq_entry_t sqQ[$];
    logic      mFlush;
    logic [31:0] mRetire;
    int checkCount = 0;
    int errorCount = 0;

    commit_unit dut (
        .clk(clk), .reset(reset), .commit(commit), .commit_rob(commit_rob),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_tag(rf_tag),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .commit_stall(commit_stall), .pred_update(pred_update), .pht_index(pht_index),
        .pht_state(pht_state), .pht_taken(pht_taken), .btb_we(btb_we), .btb_pc(btb_pc),
        .btb_target(btb_target), .cpu_reset(cpu_reset), .prior_commit(prior_commit),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .status_restore(status_restore), .status_snap(status_snap), .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic commit_bus_t mkCommit(input logic v, input logic [3:0] info,
            input logic [31:0] dest, input logic [31:0] res, input logic [5:0] cf,
            input logic [31:0] target, input logic [31:0] pc, input logic [7:0] pidx,
            input logic [31:0] snap);
        commit_bus_t c;
        c.validCommit = v;   c.commitInfo = info;  c.destCommit = dest; c.result = res;
        c.controlFlow = cf;  c.targetAddress = target; c.oldPC = pc;
        c.previousIndex = pidx; c.statusSnap = snap;
        return c;
    endfunction

    task automatic checkAllZero();
        checkEq("rst_rf_we", {31'd0, rf_we}, 32'd0);
        checkEq("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        checkEq("rst_rf_data", rf_data, 32'd0);
        checkEq("rst_rf_tag", {29'd0, rf_tag}, 32'd0);
        checkEq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        checkEq("rst_mem_addr", mem_addr, 32'd0);
        checkEq("rst_mem_data", mem_data, 32'd0);
        checkEq("rst_stall", {31'd0, commit_stall}, 32'd0);
        checkEq("rst_pred", {22'd0, pred_update, pht_index, pht_state, pht_taken}, 32'd0);
        checkEq("rst_btb_we", {31'd0, btb_we}, 32'd0);
        checkEq("rst_btb_pc", btb_pc | btb_target, 32'd0);
        checkEq("rst_flush", {28'd0, cpu_reset, redirect_valid, status_restore, prior_commit}, 32'd0);
        checkEq("rst_redirect_pc", redirect_pc | status_snap, 32'd0);
        checkEq("rst_retire", retire_count, 32'd0);
        checkEq("rst_fsm_run", {31'd0, dut.state_r}, 32'd0);
    endtask

    task automatic applyReset(input int cycles);
        reset = 1'b0;
        commit = mkCommit(1'b1, 4'b1100, 32'd3, 32'h55, 6'b100001, 32'h40, 32'h0, 8'h0, 32'h0);
        repeat (cycles) @(posedge clk);
        #1;
        expQ.delete(); sqQ.delete(); mFlush = 1'b0; mRetire = 32'd0;
        checkAllZero();
        reset = 1'b1;
        commit = mkCommit(1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 32'd0, 32'd0, 8'd0, 32'd0);
    endtask

    // One clock: drive a commit, predict its effects, compare after the edge
    task automatic cycle(input commit_bus_t c, input logic [2:0] rob, input logic rdy);
        exp_t e;
        logic acc, nextFlush, doDeq, doEnq;
        int preSize;
        commit = c; commit_rob = rob; mem_ready = rdy;
        e = '{default: 0};
        acc = c.validCommit && !mFlush;
        nextFlush = 1'b0;
        if (acc && c.commitInfo[3] && c.destCommit[4:0] != 5'd0) begin
            e.rfWe = 1'b1; e.rfAddr = c.destCommit[4:0]; e.rfData = c.result; e.rfTag = rob;
        end
        if (acc && c.controlFlow[5]) begin
            e.pred = 1'b1; e.phtIndex = c.previousIndex; e.phtState = c.controlFlow[4:3];
            e.phtTaken = c.controlFlow[1]; e.btbWe = c.controlFlow[2];
            e.btbPc = c.oldPC; e.btbTarget = c.targetAddress;
        end
        if (acc && c.controlFlow[0]) begin
            e.flush = 1'b1; e.redirectPc = c.targetAddress; e.snap = c.statusSnap;
            nextFlush = 1'b1;
        end
        if (acc) mRetire = mRetire + 32'd1;
        e.prior = acc;
        e.retire = mRetire;
        expQ.push_back(e);
        preSize = sqQ.size();
        doDeq = (preSize > 0) && rdy;
        doEnq = acc && c.commitInfo[2] && (preSize < 4);
        @(posedge clk);
        #1;
        if (doDeq) void'(sqQ.pop_front());
        if (doEnq) sqQ.push_back('{addr: c.destCommit, data: c.result});
        mFlush = nextFlush;
        if (expQ.size() == 0) begin
            checkEq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkEq("rf_we", {31'd0, rf_we}, {31'd0, e.rfWe});
            if (e.rfWe) begin
                checkEq("rf_addr", {27'd0, rf_addr}, {27'd0, e.rfAddr});
                checkEq("rf_data", rf_data, e.rfData);
                checkEq("rf_tag", {29'd0, rf_tag}, {29'd0, e.rfTag});
            end
            checkEq("pred_update", {31'd0, pred_update}, {31'd0, e.pred});
            checkEq("btb_we", {31'd0, btb_we}, {31'd0, e.btbWe});
            if (e.pred) begin
                checkEq("pht", {21'd0, pht_index, pht_state, pht_taken},
                        {21'd0, e.phtIndex, e.phtState, e.phtTaken});
                checkEq("btb_pc", btb_pc, e.btbPc);
                checkEq("btb_target", btb_target, e.btbTarget);
            end
            checkEq("flush_strobes", {29'd0, cpu_reset, redirect_valid, status_restore},
                    {29'd0, e.flush, e.flush, e.flush});
            if (e.flush) begin
                checkEq("redirect_pc", redirect_pc, e.redirectPc);
                checkEq("status_snap", status_snap, e.snap);
            end
            checkEq("prior_commit", {31'd0, prior_commit}, {31'd0, e.prior});
            checkEq("retire_count", retire_count, e.retire);
        end
        checkEq("mem_valid", {31'd0, mem_valid}, {31'd0, sqQ.size() != 0});
        if (sqQ.size() != 0) begin
            checkEq("mem_addr", mem_addr, sqQ[0].addr);
            checkEq("mem_data", mem_data, sqQ[0].data);
        end
        checkEq("commit_stall", {31'd0, commit_stall}, {31'd0, sqQ.size() >= 3});
    endtask

    initial begin
        commit_bus_t idle;
        idle = mkCommit(1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        commit = idle; commit_rob = 3'd0; mem_ready = 1'b0; reset = 1'b0;
        mFlush = 1'b0; mRetire = 32'd0;
        applyReset(2);

        // ALU write and suppressed x0 write
        cycle(mkCommit(1'b1, 4'b1000, 32'd5, 32'hDEADBEEF, 6'd0, 32'd0, 32'd0, 8'd0, 32'd0), 3'd3, 1'b0);
        cycle(mkCommit(1'b1, 4'b1000, 32'd0, 32'h12345678, 6'd0, 32'd0, 32'd0, 8'd0, 32'd0), 3'd4, 1'b0);
        cycle(idle, 3'd0, 1'b0);

        // Four stores with memory stalled, then drain in order
        for (int i = 0; i < 4; i++)
            cycle(mkCommit(1'b1, 4'b0100, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 6'd0,
                           32'd0, 32'd0, 8'd0, 32'd0), 3'(i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(idle, 3'd0, 1'b1);

        // Correctly predicted branch: predictor and BTB update, no flush
        cycle(mkCommit(1'b1, 4'b0001, 32'd0, 32'd0, 6'b110110, 32'h80, 32'h40, 8'h3A, 32'd0), 3'd1, 1'b1);

        // Mispredict with its own write, followed by a commit that must be dropped
        cycle(mkCommit(1'b1, 4'b1001, 32'd7, 32'h77, 6'b101001, 32'h200, 32'h44, 8'h11, 32'hCAFE), 3'd2, 1'b1);
        cycle(mkCommit(1'b1, 4'b1100, 32'd9, 32'h99, 6'd0, 32'h0, 32'h0, 8'h0, 32'h0), 3'd3, 1'b1);
        cycle(mkCommit(1'b1, 4'b1000, 32'd10, 32'hAA, 6'd0, 32'h0, 32'h0, 8'h0, 32'h0), 3'd4, 1'b1);

        // Mixed random commits with memory always ready
        for (int i = 0; i < 16; i++)
            cycle(mkCommit(1'($urandom_range(0, 1)), 4'($urandom), 32'h400 + 32'($urandom_range(0, 31)),
                           $urandom, 6'($urandom) & 6'b111110 | 6'(i % 5 == 4),
                           $urandom, $urandom, 8'($urandom), $urandom), 3'($urandom), 1'b1);
        for (int i = 0; i < 2; i++) cycle(idle, 3'd0, 1'b1);

        // Reset asserted while in FLUSH with two stores queued
        cycle(mkCommit(1'b1, 4'b0100, 32'h300, 32'h1, 6'd0, 32'd0, 32'd0, 8'd0, 32'd0), 3'd0, 1'b0);
        cycle(mkCommit(1'b1, 4'b0100, 32'h304, 32'h2, 6'd0, 32'd0, 32'd0, 8'd0, 32'd0), 3'd1, 1'b0);
        cycle(mkCommit(1'b1, 4'b0000, 32'd0, 32'd0, 6'b000001, 32'h500, 32'd0, 8'd0, 32'h7), 3'd2, 1'b0);
        checkEq("fsm_in_flush", {31'd0, dut.state_r}, 32'd1);
        applyReset(1);
        cycle(mkCommit(1'b1, 4'b1000, 32'd12, 32'hBEEF, 6'd0, 32'd0, 32'd0, 8'd0, 32'd0), 3'd5, 1'b1);
        cycle(idle, 3'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
